// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite definitions for the ready/valid <-> AXI-Lite bridges.
//   RESP_*        : BRESP/RRESP encodings
//   PROT_DEFAULT  : AxPROT value driven by the masters (unprivileged, secure, data)
//   rv2axil_state_e : FSM states of ready_valid_to_axi_lite
//   resp_is_error : true for SLVERR/DECERR
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } rv2axil_state_e;

  // SLVERR and DECERR share the upper bit; OKAY and EXOKAY do not set it.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/ready_valid_to_axi_lite.sv
// -----------------------------------------------------------------------------
// ready_valid_to_axi_lite
// AXI4-Lite master driven from a ready/valid command port. Each accepted
// command runs exactly one AXI-Lite read or write; the result comes back on a
// ready/valid response port. Only one transaction is in flight at a time.
//
// Ports
//   M00_AXI_aclk / M00_AXI_reset : clock, synchronous active-high reset
//   cmd_*  : command in  (valid/ready, write flag, addr, wdata, wstrb)
//   rsp_*  : response out (valid/ready, rdata, resp, error = SLVERR/DECERR)
//   M00_AXI_* : AXI4-Lite master channels AW, W, B, AR, R
//
// Only a 32-bit data width is supported. cmd_ready_o is the one
// combinational output; everything else is registered.
// -----------------------------------------------------------------------------
module ready_valid_to_axi_lite
  import axi_lite_pkg::*;
#(
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int C_M00_AXI_DATA_WIDTH = 32
) (
  input  logic                              M00_AXI_aclk,
  input  logic                              M00_AXI_reset,
  // command port
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic                              cmd_write_i,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] cmd_wstrb_i,
  // response port
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]                        rsp_resp_o,
  output logic                              rsp_error_o,
  // AXI4-Lite write address
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   M00_AXI_awaddr,
  output logic [2:0]                        M00_AXI_awprot,
  output logic                              M00_AXI_awvalid,
  input  logic                              M00_AXI_awready,
  // AXI4-Lite write data
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   M00_AXI_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] M00_AXI_wstrb,
  output logic                              M00_AXI_wvalid,
  input  logic                              M00_AXI_wready,
  // AXI4-Lite write response
  input  logic [1:0]                        M00_AXI_bresp,
  input  logic                              M00_AXI_bvalid,
  output logic                              M00_AXI_bready,
  // AXI4-Lite read address
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   M00_AXI_araddr,
  output logic [2:0]                        M00_AXI_arprot,
  output logic                              M00_AXI_arvalid,
  input  logic                              M00_AXI_arready,
  // AXI4-Lite read data
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   M00_AXI_rdata,
  input  logic [1:0]                        M00_AXI_rresp,
  input  logic                              M00_AXI_rvalid,
  output logic                              M00_AXI_rready
);

  rv2axil_state_e state;

  // Sticky completion flags for the two independent write-request channels.
  logic aw_done;
  logic w_done;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = M00_AXI_awvalid & M00_AXI_awready;
  assign w_hs  = M00_AXI_wvalid  & M00_AXI_wready;

  assign cmd_ready_o    = (state == ST_IDLE) & ~M00_AXI_reset;
  assign M00_AXI_awprot = PROT_DEFAULT;
  assign M00_AXI_arprot = PROT_DEFAULT;

  always_ff @(posedge M00_AXI_aclk) begin
    if (M00_AXI_reset) begin
      // An aborted command is dropped silently; valids fall regardless of
      // any pending handshake since the whole system is being reset.
      state           <= ST_IDLE;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      M00_AXI_awaddr  <= '0;
      M00_AXI_awvalid <= 1'b0;
      M00_AXI_wdata   <= '0;
      M00_AXI_wstrb   <= '0;
      M00_AXI_wvalid  <= 1'b0;
      M00_AXI_bready  <= 1'b0;
      M00_AXI_araddr  <= '0;
      M00_AXI_arvalid <= 1'b0;
      M00_AXI_rready  <= 1'b0;
      rsp_valid_o     <= 1'b0;
      rsp_rdata_o     <= '0;
      rsp_resp_o      <= RESP_OKAY;
      rsp_error_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // cmd_ready_o is high throughout IDLE outside reset.
          if (cmd_valid_i) begin
            if (cmd_write_i) begin
              M00_AXI_awaddr  <= cmd_addr_i;
              M00_AXI_wdata   <= cmd_wdata_i;
              M00_AXI_wstrb   <= cmd_wstrb_i;
              M00_AXI_awvalid <= 1'b1;
              M00_AXI_wvalid  <= 1'b1;
              aw_done         <= 1'b0;
              w_done          <= 1'b0;
              state           <= ST_WR_REQ;
            end else begin
              M00_AXI_araddr  <= cmd_addr_i;
              M00_AXI_arvalid <= 1'b1;
              state           <= ST_RD_REQ;
            end
          end
        end

        ST_WR_REQ: begin
          // AW and W complete independently, in any order or together.
          if (aw_hs) begin
            M00_AXI_awvalid <= 1'b0;
            aw_done         <= 1'b1;
          end
          if (w_hs) begin
            M00_AXI_wvalid <= 1'b0;
            w_done         <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            M00_AXI_bready <= 1'b1;
            state          <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (M00_AXI_bvalid) begin
            M00_AXI_bready <= 1'b0;
            rsp_rdata_o    <= '0;
            rsp_resp_o     <= M00_AXI_bresp;
            rsp_error_o    <= resp_is_error(M00_AXI_bresp);
            rsp_valid_o    <= 1'b1;
            state          <= ST_RSP;
          end
        end

        ST_RD_REQ: begin
          if (M00_AXI_arready) begin
            M00_AXI_arvalid <= 1'b0;
            M00_AXI_rready  <= 1'b1;
            state           <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          // Read data is forwarded even when the slave flags an error.
          if (M00_AXI_rvalid) begin
            M00_AXI_rready <= 1'b0;
            rsp_rdata_o    <= M00_AXI_rdata;
            rsp_resp_o     <= M00_AXI_rresp;
            rsp_error_o    <= resp_is_error(M00_AXI_rresp);
            rsp_valid_o    <= 1'b1;
            state          <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_resp_o  <= RESP_OKAY;
            rsp_error_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ready_valid_to_axi_lite.sv
// -----------------------------------------------------------------------------
// tb_ready_valid_to_axi_lite
// Bench for ready_valid_to_axi_lite. A cycle-stepped behavioural AXI-Lite
// slave with programmable wait states answers each command; the expected
// response is derived from the command and the slave's chosen answer.
// -----------------------------------------------------------------------------
module tb_ready_valid_to_axi_lite;

  localparam int BUDGET = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_error;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ready_valid_to_axi_lite #(
    .C_M00_AXI_ADDR_WIDTH(32),
    .C_M00_AXI_DATA_WIDTH(32)
  ) dut (
    .M00_AXI_aclk(clk),       .M00_AXI_reset(rst),
    .cmd_valid_i(cmd_valid),  .cmd_ready_o(cmd_ready),   .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr),    .cmd_wdata_i(cmd_wdata),   .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid),  .rsp_ready_i(rsp_ready),   .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp),    .rsp_error_o(rsp_error),
    .M00_AXI_awaddr(awaddr),  .M00_AXI_awprot(awprot),   .M00_AXI_awvalid(awvalid),
    .M00_AXI_awready(awready),
    .M00_AXI_wdata(wdata),    .M00_AXI_wstrb(wstrb),     .M00_AXI_wvalid(wvalid),
    .M00_AXI_wready(wready),
    .M00_AXI_bresp(bresp),    .M00_AXI_bvalid(bvalid),   .M00_AXI_bready(bready),
    .M00_AXI_araddr(araddr),  .M00_AXI_arprot(arprot),   .M00_AXI_arvalid(arvalid),
    .M00_AXI_arready(arready),
    .M00_AXI_rdata(rdata),    .M00_AXI_rresp(rresp),     .M00_AXI_rvalid(rvalid),
    .M00_AXI_rready(rready)
  );

  // One command through the DUT against a slave with the given wait states.
  // Entered and left just after a falling edge. Latencies are counted in
  // cycles after the command handshake (-1 = never seen).
  task automatic run_txn(
    input  bit          wr,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [3:0]  ws,
    input  int          aw_dly, input int w_dly, input int b_dly,
    input  int          ar_dly, input int r_dly, input int rsp_dly,
    input  logic [1:0]  sresp,
    input  logic [31:0] srdata,
    input  bit          hold_cmd,
    output int          lat_req, output int lat_b, output int lat_rsp,
    output int          acc_wait);
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_err;
    bit aw_ok = 0, w_ok = 0, ar_ok = 0, b_ok = 0, r_ok = 0, rsp_ok = 0, done = 0;
    bit aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, rsp_hs = 0;
    int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0, rsp_n = 0;

    // Reference: writes return zero data, reads return what the slave sent;
    // the error flag marks slave and decode errors only.
    exp_rdata = wr ? 32'h0 : srdata;
    exp_resp  = sresp;
    exp_err   = (sresp == 2'b10) || (sresp == 2'b11);
    lat_req = -1; lat_b = -1; lat_rsp = -1; acc_wait = 0;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    while (cmd_ready !== 1'b1 && acc_wait < BUDGET) begin
      @(negedge clk);
      acc_wait++;
    end
    if (acc_wait >= BUDGET) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end

    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      if (!hold_cmd) cmd_valid = 1'b0;
      if (aw_hs) aw_ok = 1;
      if (w_hs) w_ok = 1;
      if (ar_hs) ar_ok = 1;
      if (b_hs) b_ok = 1;
      if (r_hs) r_ok = 1;
      if (rsp_hs) rsp_ok = 1;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; rsp_hs = 0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0; rsp_ready = 1'b0;

      if (rsp_ok) begin
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
          errors++;
          $display("FAIL post_rsp: cmd_ready=%b rsp_valid=%b rdata=%h resp=%b required 1 0 0 00",
                   cmd_ready, rsp_valid, rsp_rdata, rsp_resp);
        end
        done = 1;
        break;
      end

      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++; $display("FAIL busy_cmd_ready: cyc %0d got %b required 0", cyc, cmd_ready);
      end

      if (wr) begin
        checks++;
        if ((arvalid | rready) !== 1'b0 || awvalid !== !aw_ok || wvalid !== !w_ok) begin
          errors++;
          $display("FAIL wr_valids: cyc %0d aw=%b w=%b ar=%b rr=%b required %b %b 0 0",
                   cyc, awvalid, wvalid, arvalid, rready, !aw_ok, !w_ok);
        end
        if (awvalid && !aw_ok) begin
          if (lat_req < 0) lat_req = cyc;
          checks++;
          if (awaddr !== addr || awprot !== 3'b000) begin
            errors++; $display("FAIL awaddr: got %h/%b required %h/000", awaddr, awprot, addr);
          end
          if (aw_n >= aw_dly) begin awready = 1'b1; aw_hs = 1; end else aw_n++;
        end
        if (wvalid && !w_ok) begin
          if (lat_req < 0) lat_req = cyc;
          checks++;
          if (wdata !== wd || wstrb !== ws) begin
            errors++; $display("FAIL wdata: got %h/%h required %h/%h", wdata, wstrb, wd, ws);
          end
          if (w_n >= w_dly) begin wready = 1'b1; w_hs = 1; end else w_n++;
        end
        checks++;
        if (bready !== (aw_ok && w_ok && !b_ok)) begin
          errors++; $display("FAIL bready: cyc %0d got %b required %b", cyc, bready, aw_ok && w_ok && !b_ok);
        end
        if (aw_ok && w_ok && !b_ok) begin
          if (lat_b < 0) lat_b = cyc;
          if (b_n >= b_dly) begin bvalid = 1'b1; bresp = sresp; b_hs = (bready === 1'b1); end
          else b_n++;
        end else bvalid = 1'b0;
      end else begin
        checks++;
        if ((awvalid | wvalid | bready) !== 1'b0 || arvalid !== !ar_ok) begin
          errors++;
          $display("FAIL rd_valids: cyc %0d aw=%b w=%b br=%b ar=%b required 0 0 0 %b",
                   cyc, awvalid, wvalid, bready, arvalid, !ar_ok);
        end
        if (arvalid && !ar_ok) begin
          if (lat_req < 0) lat_req = cyc;
          checks++;
          if (araddr !== addr || arprot !== 3'b000) begin
            errors++; $display("FAIL araddr: got %h/%b required %h/000", araddr, arprot, addr);
          end
          if (ar_n >= ar_dly) begin arready = 1'b1; ar_hs = 1; end else ar_n++;
        end
        checks++;
        if (rready !== (ar_ok && !r_ok)) begin
          errors++; $display("FAIL rready: cyc %0d got %b required %b", cyc, rready, ar_ok && !r_ok);
        end
        if (ar_ok && !r_ok) begin
          if (lat_b < 0) lat_b = cyc;
          if (r_n >= r_dly) begin
            rvalid = 1'b1; rdata = srdata; rresp = sresp; r_hs = (rready === 1'b1);
          end else r_n++;
        end else rvalid = 1'b0;
      end

      checks++;
      if (rsp_valid !== (b_ok || r_ok)) begin
        errors++; $display("FAIL rsp_valid: cyc %0d got %b required %b", cyc, rsp_valid, b_ok || r_ok);
      end
      if (rsp_valid === 1'b1) begin
        if (lat_rsp < 0) lat_rsp = cyc;
        checks++;
        if (rsp_rdata !== exp_rdata || rsp_resp !== exp_resp || rsp_error !== exp_err) begin
          errors++;
          $display("FAIL rsp_payload: got %h/%b/%b required %h/%b/%b",
                   rsp_rdata, rsp_resp, rsp_error, exp_rdata, exp_resp, exp_err);
        end
        if (rsp_n >= rsp_dly) begin rsp_ready = 1'b1; rsp_hs = 1; end else rsp_n++;
      end
    end

    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout: no response within %0d cycles, required one", BUDGET);
    end
    bvalid = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
    rsp_ready = 1'b0;
    if (!hold_cmd) cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || {awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0 ||
        awaddr !== 32'h0 || araddr !== 32'h0 || wdata !== 32'h0 || rsp_rdata !== 32'h0 ||
        rsp_resp !== 2'b00 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cmd_ready=%b valids=%b rdata=%h required 0 000000 0", cmd_ready,
               {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, rsp_rdata);
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_zero_wait();
    int lq, lb, lr, aw;
    run_txn(1, 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, lq, lb, lr, aw);
    checks++;
    if (lq != 1 || lb != 2 || lr != 3) begin
      errors++; $display("FAIL wr_latency: got %0d/%0d/%0d required 1/2/3", lq, lb, lr);
    end
    run_txn(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b01, 32'hCAFE_0001, 0, lq, lb, lr, aw);
    checks++;
    if (lq != 1 || lb != 2 || lr != 3) begin
      errors++; $display("FAIL rd_latency: got %0d/%0d/%0d required 1/2/3", lq, lb, lr);
    end
  endtask

  task automatic test_read_wait();
    int lq, lb, lr, aw;
    run_txn(0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 5, 3, 0, 2'b00, 32'h1234_5678, 0, lq, lb, lr, aw);
    checks++;
    if (lq != 1 || lb != 7 || lr != 11) begin
      errors++; $display("FAIL rd_wait_latency: got %0d/%0d/%0d required 1/7/11", lq, lb, lr);
    end
  endtask

  task automatic test_write_order();
    int lq, lb, lr, aw;
    run_txn(1, 32'h20, 32'hA5A5_0F0F, 4'h3, 5, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, lq, lb, lr, aw);
    checks++;
    if (lb != 7) begin
      errors++; $display("FAIL w_first_bready: got %0d required 7", lb);
    end
    run_txn(1, 32'h24, 32'h0F0F_A5A5, 4'hC, 0, 5, 2, 0, 0, 0, 2'b00, 32'h0, 0, lq, lb, lr, aw);
    checks++;
    if (lb != 7 || lr != 10) begin
      errors++; $display("FAIL aw_first_timing: got %0d/%0d required 7/10", lb, lr);
    end
  endtask

  task automatic test_errors();
    int lq, lb, lr, aw;
    run_txn(0, 32'h30, 32'h0, 4'h0, 0, 0, 0, 1, 1, 0, 2'b10, 32'hBAD0_BAD0, 0, lq, lb, lr, aw);
    run_txn(1, 32'h34, 32'h5555_AAAA, 4'hF, 1, 2, 1, 0, 0, 1, 2'b11, 32'h0, 0, lq, lb, lr, aw);
  endtask

  task automatic test_back_to_back();
    int lq, lb, lr, aw;
    run_txn(1, 32'h40, 32'h0000_0042, 4'h1, 0, 0, 0, 0, 0, 10, 2'b00, 32'h0, 1, lq, lb, lr, aw);
    run_txn(0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h7777_8888, 0, lq, lb, lr, aw);
    checks++;
    if (aw != 0) begin
      errors++; $display("FAIL second_accept: waited %0d cycles required 0", aw);
    end
  endtask

  task automatic test_stray();
    bvalid = 1'b1; bresp = 2'b10; rvalid = 1'b1; rresp = 2'b11; rdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bready !== 1'b0 || rready !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL stray_resp: br=%b rr=%b rsp_valid=%b cmd_ready=%b required 0 0 0 1",
                 bready, rready, rsp_valid, cmd_ready);
      end
    end
    bvalid = 1'b0; rvalid = 1'b0;
  endtask

  task automatic test_random();
    int lq, lb, lr, aw;
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
              2'($urandom), $urandom, 0, lq, lb, lr, aw);
    end
  endtask

  task automatic test_reset_mid();
    int lq, lb, lr, aw;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
      errors++; $display("FAIL mid_setup: aw=%b w=%b required 1 1", awvalid, wvalid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valids=%b cmd_ready=%b required 000000 0",
               {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, cmd_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
        errors++;
        $display("FAIL mid_release: cmd_ready=%b rsp_valid=%b aw=%b w=%b required 1 0 0 0",
                 cmd_ready, rsp_valid, awvalid, wvalid);
      end
    end
    run_txn(0, 32'h54, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 0, lq, lb, lr, aw);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    test_reset();
    test_zero_wait();
    test_read_wait();
    test_write_order();
    test_errors();
    test_back_to_back();
    test_stray();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ready_valid_to_axi_lite.md
Name: ready_valid_to_axi_lite

Overview:
- AXI4-Lite master: the initiator end of the AXI-Lite/ready-valid bridge.
- Accepts single read or write commands on a ready/valid command port, runs one AXI4-Lite transaction per command, and returns data plus status on a ready/valid response port.
- Lets fabric logic (sequencers, test engines) drive AXI-Lite register slaves such as the team's port bridges.
- One transaction outstanding at a time.

Parameters:
- C_M00_AXI_ADDR_WIDTH, 32, AXI address width; cmd_addr_i is passed through unmodified.
- C_M00_AXI_DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- M00_AXI_aclk  in  1  single clock for all logic
- M00_AXI_reset  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  byte address
- cmd_wdata_i  in  32  write data (ignored for reads)
- cmd_wstrb_i  in  4  write strobes (ignored for reads)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  32  read data; 0 for writes
- rsp_resp_o  out  2  captured BRESP/RRESP
- rsp_error_o  out  1  rsp_resp_o[1] (SLVERR or DECERR)
- M00_AXI_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite master directions and widths; awprot=arprot=3'b000 constant.

Behaviour:
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- Reset: state IDLE. All valid/ready outputs 0 during reset. All data/addr/resp outputs 0.
- cmd_ready_o = (state==IDLE) & !M00_AXI_reset. It is the only combinational output; all AXI valids/readies and rsp_* are registered.
- IDLE, on cmd handshake: latch addr/wdata/wstrb.
  - Write -> WR_REQ with awvalid=1 and wvalid=1 from the next cycle.
  - Read -> RD_REQ with arvalid=1.
- WR_REQ: two independent sticky flags, aw_done and w_done.
  - awvalid drops the cycle after the aw handshake; wvalid likewise after the w handshake.
  - Handshakes may occur in either order or in the same cycle.
  - When both are done -> WR_RESP.
- WR_RESP: bready=1. On the b handshake: capture bresp, set rdata=0, bready=0 -> RSP.
- RD_REQ: arvalid held until arready -> RD_DATA.
- RD_DATA: rready=1. On the r handshake: capture rdata and rresp, rready=0 -> RSP.
- RSP: rsp_valid_o=1; rsp_* stable while rsp_ready_i=0. On the rsp handshake: rsp_valid_o=0, data/resp cleared to 0 -> IDLE. cmd_ready_o rises in the same cycle the FSM enters IDLE.
- Master valids never drop before their handshake (AXI rule).
- bready/rready are asserted only in WR_RESP/RD_DATA. A stray bvalid/rvalid in other states is ignored.
- Minimum latency with zero-wait slaves: cmd handshake at cycle 0 -> AW/W at cycle 1 -> B at cycle 2 -> rsp_valid_o at cycle 3. Reads follow the same pattern: AR at cycle 1, R at cycle 2, rsp_valid_o at cycle 3.
- Next command is accepted no earlier than the cycle after the rsp handshake. Throughput is at most 1 transaction per 4 cycles.
- Reset mid-operation: next edge returns to IDLE and all valids drop. The resulting AXI violation is accepted because reset is system-wide. No response is issued for the aborted command.
- Error codes: EXOKAY (01) is passed through with rsp_error_o=0. SLVERR (10) and DECERR (11) give rsp_error_o=1. Read data on error is passed through as received.
- No timeout: a hung slave stalls the block indefinitely, by design.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - PROT_DEFAULT=3'b000
  - FSM state localparams for this block
- Single flat module; no sub-module is needed.

Test Plan:
- Write 0x4 data 0xDEADBEEF wstrb 0xF, slave zero-wait OKAY -> AW/W at cycle 1, bready at cycle 2, rsp_valid_o at cycle 3 with resp=00, error=0, rdata=0.
- Read 0x8, slave returns 0x12345678 OKAY after 5 wait cycles on arready and 3 on rvalid -> arvalid held stable until handshake; rsp_rdata_o=0x12345678, error=0.
- Write with wready at cycle 1 and awready at cycle 6 (and the reverse order) -> each valid drops after its own handshake; exactly one B accepted; one response.
- Read returns SLVERR, then a write returns DECERR -> rsp_resp_o=10/11, rsp_error_o=1 both times.
- Hold rsp_ready_i=0 for 10 cycles with cmd_valid_i=1 -> rsp_* stable; cmd_ready_o=0 throughout; the second command is accepted exactly the cycle after the rsp handshake.
- Assert M00_AXI_reset while in WR_REQ with awvalid=1 -> next cycle all valids 0, cmd_ready_o=0 during reset and 1 after release; no rsp_valid_o.
